ascii_string_rx: RTL and testbench

Byte-serial ASCII string receiver: accepts a valid/ready character stream, decodes backslash escapes (`\n`, `\t`, `\\`, `\"`, and octal `\ooo`), and packs the decoded characters into a right-justified string register with the same layout as a Verilog `reg [8*N:1]` string. The last character is in the low byte. It is the reader/decoder counterpart of the team's string writers and display formatters. It sits between a character source (UART RX, host mailbox) and logic that compares or consumes packed strings.

---
 rtl/ascii_string_pkg.sv | 28 ++
 rtl/ascii_string_rx_if.sv | 24 ++
 rtl/string_shift_buf.sv | 40 ++++
 rtl/ascii_string_rx.sv | 149 ++++++++++++++
 tb/tb_ascii_string_rx.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_string_pkg.sv
// Shared types, character constants and byte classifiers for the ASCII string receiver.
package ascii_string_pkg;

    typedef enum logic [2:0] {
        StCollect = 3'd0,
        StEsc     = 3'd1,
        StOct     = 3'd2,
        StReplay  = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_BSL = 8'h5C;
    localparam logic [7:0] CH_DQ  = 8'h22;
    localparam logic [7:0] CH_N   = 8'h6E;
    localparam logic [7:0] CH_T   = 8'h74;

    function automatic logic is_octal(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h37);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == CH_NUL) || (b == CH_LF);
    endfunction

endpackage

// File: rtl/ascii_string_rx_if.sv
// Character-stream input and packed-string output handshakes of the ASCII string receiver.
interface ascii_string_rx_if #(
    parameter int unsigned MAX_CHARS = 14,
    parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   str_valid;
    logic                   str_ready;
    logic [8*MAX_CHARS-1:0] str_data;
    logic [LEN_W-1:0]       str_len;
    logic                   str_ovf;

    modport master (
        output in_valid, in_data, str_ready,
        input  in_ready, str_valid, str_data, str_len, str_ovf
    );

    modport slave (
        input  in_valid, in_data, str_ready,
        output in_ready, str_valid, str_data, str_len, str_ovf
    );
endinterface

// File: rtl/string_shift_buf.sv
// Right-justified packed character buffer with length counter and sticky overflow flag.
module string_shift_buf #(
    parameter int unsigned MAX_CHARS = 14,
    parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic [7:0]             ch,
    input  logic                   clear,
    output logic [8*MAX_CHARS-1:0] data,
    output logic [LEN_W-1:0]       len,
    output logic                   ovf
);

    logic [8*MAX_CHARS-1:0] data_q;
    logic [LEN_W-1:0]       len_q;
    logic                   ovf_q;

    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            data_q <= '0;
            len_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (push) begin
            // A full buffer keeps its contents; the dropped char only raises ovf.
            if (len_q < LEN_W'(MAX_CHARS)) begin
                data_q <= {data_q[8*MAX_CHARS-9:0], ch};
                len_q  <= len_q + LEN_W'(1);
            end else begin
                ovf_q  <= 1'b1;
            end
        end
    end

    assign data = data_q;
    assign len  = len_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/ascii_string_rx.sv
// Byte-serial ASCII string receiver: escape/octal decoding FSM feeding a packed string buffer.
module ascii_string_rx
    import ascii_string_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 14,
    parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
) (
    input logic             clk,
    input logic             nrst,
    ascii_string_rx_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] pend_q, pend_d;
    logic       in_ready_q;
    logic       str_valid_q;

    logic       fire;
    logic [7:0] cur;
    logic [7:0] acc_next;
    logic       push;
    logic [7:0] ch;
    logic       clear;

    logic [8*MAX_CHARS-1:0] buf_data;
    logic [LEN_W-1:0]       buf_len;
    logic                   buf_ovf;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        push     = 1'b0;
        ch       = 8'h00;
        clear    = 1'b0;
        fire     = bus.in_valid && in_ready_q;
        cur      = (state_q == StReplay) ? pend_q : bus.in_data;
        acc_next = {acc_q[4:0], 3'b000} + {5'b00000, bus.in_data[2:0]};
        case (state_q)
            // Replay re-runs the byte that ended an octal escape through the collect rules.
            StCollect, StReplay: begin
                if (fire || state_q == StReplay) begin
                    if (is_term(cur)) begin
                        state_d = StDone;
                    end else if (cur == CH_BSL) begin
                        state_d = StEsc;
                    end else begin
                        push    = 1'b1;
                        ch      = cur;
                        state_d = StCollect;
                    end
                end
            end
            StEsc: begin
                if (fire) begin
                    if (is_term(bus.in_data)) begin
                        state_d = StDone;
                    end else if (is_octal(bus.in_data)) begin
                        acc_d   = {5'b00000, bus.in_data[2:0]};
                        cnt_d   = 2'd1;
                        state_d = StOct;
                    end else begin
                        push    = 1'b1;
                        state_d = StCollect;
                        case (bus.in_data)
                            CH_N:    ch = CH_LF;
                            CH_T:    ch = CH_TAB;
                            default: ch = bus.in_data;
                        endcase
                    end
                end
            end
            StOct: begin
                if (fire) begin
                    if (is_term(bus.in_data)) begin
                        push    = 1'b1;
                        ch      = acc_q;
                        state_d = StDone;
                    end else if (is_octal(bus.in_data)) begin
                        if (cnt_q == 2'd2) begin
                            push    = 1'b1;
                            ch      = acc_next;
                            cnt_d   = 2'd0;
                            state_d = StCollect;
                        end else begin
                            acc_d = acc_next;
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else begin
                        push    = 1'b1;
                        ch      = acc_q;
                        pend_d  = bus.in_data;
                        state_d = StReplay;
                    end
                end
            end
            StDone: begin
                if (bus.str_ready) begin
                    clear   = 1'b1;
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // Handshake outputs are registered from the next state so they read 0 throughout reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= StCollect;
            acc_q       <= 8'h00;
            cnt_q       <= 2'd0;
            pend_q      <= 8'h00;
            in_ready_q  <= 1'b0;
            str_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            in_ready_q  <= (state_d == StCollect) || (state_d == StEsc) || (state_d == StOct);
            str_valid_q <= (state_d == StDone);
        end
    end

    string_shift_buf #(
        .MAX_CHARS(MAX_CHARS),
        .LEN_W    (LEN_W)
    ) u_buf (
        .clk  (clk),
        .nrst (nrst),
        .push (push),
        .ch   (ch),
        .clear(clear),
        .data (buf_data),
        .len  (buf_len),
        .ovf  (buf_ovf)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.str_valid = str_valid_q;
    assign bus.str_data  = buf_data;
    assign bus.str_len   = buf_len;
    assign bus.str_ovf   = buf_ovf;

endmodule

// File: tb/tb_ascii_string_rx.sv
// Self-checking bench for ascii_string_rx: directed scenarios plus random strings vs a parser model.
module tb_ascii_string_rx;

    localparam int MAXC = 14;
    typedef logic [8*MAXC-1:0] str_t;
    typedef logic [7:0] bq_t[$];

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   stalls   = 0;

    ascii_string_rx_if #(.MAX_CHARS(MAXC)) bus ();

    ascii_string_rx #(.MAX_CHARS(MAXC)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic tb_is_oct(input logic [7:0] b);
        return b >= "0" && b <= "7";
    endfunction

    // Reference: parse the byte list left to right as a string literal would be read.
    function automatic void model(input bq_t q, output str_t d, output int len, output logic ovf);
        bq_t chars;
        int  i = 0;
        int  val;
        int  k;
        logic [7:0] e;
        while (i < q.size()) begin
            if (q[i] == 8'h00 || q[i] == 8'h0A) break;
            if (q[i] != 8'h5C) begin
                chars.push_back(q[i]);
                i++;
                continue;
            end
            i++;
            if (i >= q.size()) break;
            e = q[i];
            if (e == 8'h00 || e == 8'h0A) break;
            if (e == "n") begin chars.push_back(8'h0A); i++; end
            else if (e == "t") begin chars.push_back(8'h09); i++; end
            else if (tb_is_oct(e)) begin
                val = int'(e) - 48;
                k = 1;
                i++;
                while (k < 3 && i < q.size() && tb_is_oct(q[i])) begin
                    val = val * 8 + (int'(q[i]) - 48);
                    k++;
                    i++;
                end
                chars.push_back(8'(val % 256));
            end else begin
                chars.push_back(e);
                i++;
            end
        end
        d = '0;
        len = 0;
        ovf = 1'b0;
        for (int c = 0; c < chars.size(); c++) begin
            if (c < MAXC) begin
                d = {d[8*MAXC-9:0], chars[c]};
                len++;
            end else begin
                ovf = 1'b1;
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
            stalls++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL send_byte: in_ready=0 after %0d cycles, want 1 (byte %02h)", guard, b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Waits (bounded) for a completed string, captures it and hands it off.
    task automatic get_result(output logic got, output str_t d, output int len, output logic ovf);
        int guard = 0;
        while (!bus.str_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        got = bus.str_valid;
        d   = bus.str_data;
        len = int'(bus.str_len);
        ovf = bus.str_ovf;
        if (got) begin
            bus.str_ready = 1'b1;
            @(negedge clk);
            bus.str_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        else n_pass++;
        n_checks++;
        if ({bus.str_valid, bus.str_ovf, bus.str_len} !== 6'd0)
            $display("FAIL reset_flags: got valid=%b ovf=%b len=%0d want 0", bus.str_valid,
                     bus.str_ovf, bus.str_len);
        else n_pass++;
        n_checks++;
        if (bus.str_data !== str_t'(0)) $display("FAIL reset_data: got %h want 0", bus.str_data);
        else n_pass++;
        nrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_hello();
        bus.str_ready = 1'b1;
        send_str("Hello world");
        n_checks++;
        if (bus.str_valid !== 1'b0) $display("FAIL hello_early_valid: got %b want 0", bus.str_valid);
        else n_pass++;
        send_byte(8'h0A);
        n_checks++;
        if (bus.str_valid !== 1'b1) $display("FAIL hello_latency: got %b want 1", bus.str_valid);
        else n_pass++;
        n_checks++;
        if (bus.str_len !== 4'd11 || bus.str_ovf !== 1'b0)
            $display("FAIL hello_len: got len=%0d ovf=%b want 11/0", bus.str_len, bus.str_ovf);
        else n_pass++;
        n_checks++;
        if (bus.str_data !== str_t'(88'h48656c6c6f20776f726c64))
            $display("FAIL hello_data: got %h want 48656c6c6f20776f726c64", bus.str_data);
        else n_pass++;
        @(negedge clk);
        bus.str_ready = 1'b0;
        n_checks++;
        if (bus.str_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL hello_handoff: got valid=%b ready=%b want 0/1", bus.str_valid,
                     bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_escapes();
        bq_t  q = '{8'h61, 8'h5C, 8'h74, 8'h5C, 8'h31, 8'h32, 8'h33, 8'h5C, 8'h31, 8'h78, 8'h00};
        logic got, ovf;
        str_t d;
        int   len;
        stalls = 0;
        foreach (q[i]) send_byte(q[i]);
        n_checks++;
        if (stalls !== 1) $display("FAIL esc_bubble: got %0d stall cycles want 1", stalls);
        else n_pass++;
        get_result(got, d, len, ovf);
        n_checks++;
        if (!got || len !== 5 || ovf !== 1'b0)
            $display("FAIL esc_len: got valid=%b len=%0d ovf=%b want 1/5/0", got, len, ovf);
        else n_pass++;
        n_checks++;
        if (d !== str_t'(40'h6109530178)) $display("FAIL esc_data: got %h want 6109530178", d);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic got, ovf;
        str_t d;
        int   len;
        repeat (16) send_byte(8'h41);
        send_byte(8'h0A);
        get_result(got, d, len, ovf);
        n_checks++;
        if (!got || len !== 14 || ovf !== 1'b1)
            $display("FAIL ovf_len: got valid=%b len=%0d ovf=%b want 1/14/1", got, len, ovf);
        else n_pass++;
        n_checks++;
        if (d !== {14{8'h41}}) $display("FAIL ovf_data: got %h want all 41", d);
        else n_pass++;
    endtask

    task automatic test_empty();
        logic got, ovf;
        str_t d;
        int   len;
        send_byte(8'h0A);
        get_result(got, d, len, ovf);
        n_checks++;
        if (!got || len !== 0 || d !== str_t'(0))
            $display("FAIL empty_first: got valid=%b len=%0d data=%h want 1/0/0", got, len, d);
        else n_pass++;
        send_byte(8'h5C);
        send_byte(8'h0A);
        get_result(got, d, len, ovf);
        n_checks++;
        if (!got || len !== 0 || d !== str_t'(0))
            $display("FAIL empty_escape: got valid=%b len=%0d data=%h want 1/0/0", got, len, d);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic got, ovf;
        str_t d;
        int   len;
        bus.str_ready = 1'b0;
        send_str("hi");
        send_byte(8'h0A);
        bus.in_valid = 1'b1;
        bus.in_data  = "Z";
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.str_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.str_data !== str_t'(16'h6869))
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b data=%h want 1/0/6869", c,
                         bus.str_valid, bus.in_ready, bus.str_data);
            else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.str_ready = 1'b1;
        @(negedge clk);
        bus.str_ready = 1'b0;
        n_checks++;
        if (bus.str_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.str_len !== 4'd0)
            $display("FAIL hold_release: got valid=%b ready=%b len=%0d want 0/1/0", bus.str_valid,
                     bus.in_ready, bus.str_len);
        else n_pass++;
        send_byte("q");
        send_byte(8'h0A);
        get_result(got, d, len, ovf);
        n_checks++;
        if (!got || len !== 1 || d !== str_t'(8'h71))
            $display("FAIL hold_next: got valid=%b len=%0d data=%h want 1/1/71", got, len, d);
        else n_pass++;
    endtask

    task automatic test_midreset();
        logic got, ovf;
        str_t d;
        int   len;
        send_str("abcde");
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        n_checks++;
        if ({bus.in_ready, bus.str_valid, bus.str_ovf, bus.str_len} !== 7'd0 ||
            bus.str_data !== str_t'(0))
            $display("FAIL midreset_clear: got ready=%b valid=%b len=%0d data=%h want all 0",
                     bus.in_ready, bus.str_valid, bus.str_len, bus.str_data);
        else n_pass++;
        send_str("ok");
        send_byte(8'h0A);
        get_result(got, d, len, ovf);
        n_checks++;
        if (!got || len !== 2 || ovf !== 1'b0 || d !== str_t'(16'h6f6b))
            $display("FAIL midreset_ok: got valid=%b len=%0d data=%h want 1/2/6f6b", got, len, d);
        else n_pass++;
    endtask

    task automatic test_random();
        logic got, ovf, m_ovf;
        str_t d, m_d;
        int   len, m_len, r;
        bq_t  q;
        for (int it = 0; it < 25; it++) begin
            q.delete();
            for (int j = 0; j < int'($urandom_range(0, 22)); j++) begin
                r = int'($urandom_range(0, 9));
                if (r <= 2) q.push_back(8'h5C);
                else if (r <= 4) q.push_back(8'(48 + $urandom_range(0, 7)));
                else if (r == 5) q.push_back($urandom_range(0, 1) ? 8'h6E : 8'h74);
                else if (r == 6) q.push_back($urandom_range(0, 1) ? 8'h22 : 8'h38);
                else q.push_back(8'($urandom_range(32, 126)));
            end
            q.push_back($urandom_range(0, 1) ? 8'h0A : 8'h00);
            model(q, m_d, m_len, m_ovf);
            foreach (q[i]) send_byte(q[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            get_result(got, d, len, ovf);
            n_checks++;
            if (got !== 1'b1) $display("FAIL rand%0d_valid: got %b want 1", it, got);
            else n_pass++;
            n_checks++;
            if (len !== m_len) $display("FAIL rand%0d_len: got %0d want %0d", it, len, m_len);
            else n_pass++;
            n_checks++;
            if (ovf !== m_ovf) $display("FAIL rand%0d_ovf: got %b want %b", it, ovf, m_ovf);
            else n_pass++;
            n_checks++;
            if (d !== m_d) $display("FAIL rand%0d_data: got %h want %h", it, d, m_d);
            else n_pass++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.str_ready = 1'b0;
        test_reset();
        test_hello();
        test_escapes();
        test_overflow();
        test_empty();
        test_backpressure();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
